// File: rtl/sd_cmd_tx.sv
// SD-card CMD-line frame serialiser: start, transmission, index, argument, CRC7, end bit.
// Every bit is held for DIV system clocks; the CRC7 is built on the fly while the header shifts out.
module sd_cmd_tx #(
  parameter int unsigned DIV = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic [6:0]  crc_out
);

  localparam logic [7:0] DivLast = 8'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StCrc, StStop} state_e;

  state_e      state_q;
  logic [7:0]  div_q;
  logic [5:0]  bit_q;
  logic [39:0] shreg_q;
  logic [6:0]  crc_q;
  logic [5:0]  crc_sh_q;

  logic       adv;
  logic       inv;
  logic [6:0] crc_nxt;

  always_comb begin
    adv     = (div_q == DivLast);
    inv     = shreg_q[39] ^ crc_q[6];
    crc_nxt = {crc_q[5:3], crc_q[2] ^ inv, crc_q[1:0], inv};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      crc_q    <= '0;
      crc_sh_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cmd_out  <= 1'b1;
      cmd_oe   <= 1'b0;
      crc_out  <= '0;
    end else begin
      done <= 1'b0;
      if (state_q != StIdle) div_q <= adv ? 8'd0 : div_q + 8'd1;
      case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q <= {2'b01, cmd_index, cmd_arg};
            crc_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            busy    <= 1'b1;
            cmd_oe  <= 1'b1;
            cmd_out <= 1'b0;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (adv) begin
            crc_q   <= crc_nxt;
            shreg_q <= {shreg_q[38:0], 1'b0};
            bit_q   <= bit_q + 6'd1;
            if (bit_q == 6'd39) begin
              // Final CRC is known here, so the first CRC bit follows without a gap.
              crc_sh_q <= crc_nxt[5:0];
              crc_out  <= crc_nxt;
              cmd_out  <= crc_nxt[6];
              state_q  <= StCrc;
            end else begin
              cmd_out <= shreg_q[38];
            end
          end
        end
        StCrc: begin
          if (adv) begin
            bit_q    <= bit_q + 6'd1;
            crc_sh_q <= {crc_sh_q[4:0], 1'b0};
            if (bit_q == 6'd46) begin
              cmd_out <= 1'b1;
              state_q <= StStop;
            end else begin
              cmd_out <= crc_sh_q[5];
            end
          end
        end
        StStop: begin
          if (adv) begin
            bit_q   <= '0;
            busy    <= 1'b0;
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: three instances (DIV=1,2,3) driven with directed and random frames,
// checked cycle by cycle against a polynomial-division CRC7 frame model.
module tb_sd_cmd_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  start_v;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [2:0]  busy_v, done_v, out_v, oe_v;
  logic [6:0]  crc1, crc2, crc3;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sd_cmd_tx #(.DIV(1)) u_div1 (
    .CLK(CLK), .RST(RST), .start(start_v[0]), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .busy(busy_v[0]), .done(done_v[0]), .cmd_out(out_v[0]), .cmd_oe(oe_v[0]), .crc_out(crc1)
  );
  sd_cmd_tx #(.DIV(2)) u_div2 (
    .CLK(CLK), .RST(RST), .start(start_v[1]), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .busy(busy_v[1]), .done(done_v[1]), .cmd_out(out_v[1]), .cmd_oe(oe_v[1]), .crc_out(crc2)
  );
  sd_cmd_tx #(.DIV(3)) u_div3 (
    .CLK(CLK), .RST(RST), .start(start_v[2]), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .busy(busy_v[2]), .done(done_v[2]), .cmd_out(out_v[2]), .cmd_oe(oe_v[2]), .crc_out(crc3)
  );

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89).
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    logic [46:0] g;
    r = {msg, 7'b0};
    g = 47'h89;
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r = r ^ (g << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  // {busy, cmd_oe, done, cmd_out} of instance d
  function automatic logic [3:0] stat(input int d);
    return {busy_v[d], oe_v[d], done_v[d], out_v[d]};
  endfunction

  function automatic logic [6:0] crc_of(input int d);
    case (d)
      0:       return crc1;
      1:       return crc2;
      default: return crc3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with instance d idle. Returns at the negedge of the done cycle,
  // or of the cycle after reset when rst_s>0 (reset driven during sample rst_s).
  task automatic run_frame(input int d, input logic [5:0] idx, input logic [31:0] arg,
                           input bit hold, input bit toggle, input int pulse_s, input int rst_s);
    logic [47:0] f;
    int          div;
    int          last;
    div  = d + 1;
    last = 48 * div + 1;
    f    = frame_ref(idx, arg);
    cmd_index  = idx;
    cmd_arg    = arg;
    start_v[d] = 1'b1;
    @(posedge CLK);
    for (int s = 1; s <= last; s++) begin
      @(negedge CLK);
      if (rst_s > 0 && s == rst_s + 1) begin
        chk("reset_mid_stat", {60'd0, stat(d)}, 64'h1);
        chk("reset_mid_crc", {57'd0, crc_of(d)}, 64'h0);
        RST = 1'b1;
        start_v[d] = 1'b0;
        return;
      end
      if (s < last) chk("frame_bit", {60'd0, stat(d)}, {60'd0, 3'b110, f[47 - (s - 1) / div]});
      else chk("done_cycle", {60'd0, stat(d)}, 64'h3);
      if (s > 40 * div) chk("crc_out", {57'd0, crc_of(d)}, {57'd0, f[7:1]});
      start_v[d] = hold || (s == pulse_s);
      if (toggle) begin
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
      end
      if (rst_s > 0 && s == rst_s) RST = 1'b0;
    end
  endtask

  task automatic expect_quiet(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("quiet_after", {60'd0, stat(d)}, 64'h1);
    end
  endtask

  initial begin
    start_v   = '0;
    cmd_index = '0;
    cmd_arg   = '0;
    RST       = 1'b0;
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk("reset_stat", {60'd0, stat(d)}, 64'h1);
      chk("reset_crc", {57'd0, crc_of(d)}, 64'h0);
    end
    RST = 1'b1;
    @(negedge CLK);

    // CMD0, DIV=1
    run_frame(0, 6'd0, 32'h0, 1'b0, 1'b0, 0, 0);
    chk("cmd0_crc", {57'd0, crc1}, 64'h4A);
    expect_quiet(0, 2);

    // CMD8, DIV=2
    run_frame(1, 6'd8, 32'h1AA, 1'b0, 1'b0, 0, 0);
    chk("cmd8_crc", {57'd0, crc2}, 64'h43);
    expect_quiet(1, 2);

    // CMD17 then CMD55 back to back with start held, DIV=3
    run_frame(2, 6'd17, 32'h0, 1'b1, 1'b0, 0, 0);
    chk("cmd17_crc", {57'd0, crc3}, 64'h2A);
    run_frame(2, 6'd55, 32'h0, 1'b0, 1'b0, 0, 0);
    chk("cmd55_crc", {57'd0, crc3}, 64'h32);
    expect_quiet(2, 3);

    // start pulsed during bit 20 must be ignored
    run_frame(1, 6'($urandom), $urandom, 1'b0, 1'b0, 20 * 2 + 1, 0);
    expect_quiet(1, 4);

    // reset during bit 30, then a clean CMD0
    run_frame(2, 6'($urandom), $urandom, 1'b0, 1'b0, 0, 30 * 3 + 1);
    expect_quiet(2, 4);
    run_frame(0, 6'd0, 32'h0, 1'b0, 1'b0, 0, 0);
    chk("cmd0_after_reset_crc", {57'd0, crc1}, 64'h4A);
    expect_quiet(0, 1);

    // inputs toggled after accept
    for (int d = 0; d < 3; d++) begin
      run_frame(d, 6'($urandom), $urandom, 1'b0, 1'b1, 0, 0);
      expect_quiet(d, 1);
    end

    // random frames on random instances
    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(0, 2)), 6'($urandom), $urandom, 1'b0, 1'b0, 0, 0);
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

Serialiser for SD-card command frames on the CMD line in SPI-less native mode. It accepts a 6-bit command index and 32-bit argument, then emits the 48-bit frame MSB-first: start bit, transmission bit, index, argument, CRC7, end bit. The CRC7 is computed on the fly with polynomial x^7+x^3+1. It sits between the card-controller sequencer, which issues commands, and the CMD pad driver.

## Interface
- DIV, 2: system clocks per CMD bit; legal range 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- cmd_index  in  6  command index; latched on accept.
- cmd_arg  in  32  command argument; latched on accept.
- busy  out  1  high while a frame is in flight.
- done  out  1  one-cycle pulse after the end bit completes.
- cmd_out  out  1  serial CMD data; idles high.
- cmd_oe  out  1  pad output enable; high only while a frame is driven.
- crc_out  out  7  CRC7 of the last frame; valid from the CRC phase onward and held until the next accept.

## Operation
- States:
  - IDLE: waits for start.
  - HDR: drives 40 bits, namely start(0), transmission(1), index[5:0] and arg[31:0].
  - CRC: drives 7 bits.
  - STOP: drives the end bit(1).
  - Return to IDLE.
- Accept: in IDLE with start=1, latch the frame into a 40-bit shift register {2'b01, cmd_index, cmd_arg}, clear the CRC register to 0, clear the divider and bit counter, and go to HDR.
- Bit pacing:
  - A divider counts 0..DIV-1.
  - The bit advances when the divider reaches DIV-1.
  - Each bit is held on cmd_out for exactly DIV cycles.
- CRC update: once per HDR bit, at the advance edge, using b = the bit being driven.
  - inv = b ^ crc[6]
  - crc <= {crc[5:3], crc[2]^inv, crc[1:0], inv}
  - Net effect: shift left by one, XOR 7'h09 when inv=1.
- CRC phase:
  - Drive crc[6:0] MSB-first.
  - The CRC register is frozen; a separate 7-bit shift copy is used for output.
  - crc_out = the frozen value.
- Counters: the bit counter is 6 bits, counting 0..47. HDR covers 0..39, CRC covers 40..46, STOP is 47.
- start while busy, or in the done cycle's state other than IDLE, is ignored: no queueing, no effect on the frame.
- Inputs cmd_index/cmd_arg may change freely after the accept edge.
- Reset values (RST=0 at a rising edge):
  - state=IDLE
  - busy=0, done=0
  - cmd_out=1, cmd_oe=0
  - crc_out=0
  - counters=0
- Reset mid-frame: outputs return to reset values on the next edge, no done pulse is produced, and the frame is abandoned.

## Timing
- Start sampled high at edge N in IDLE.
  - From N+1: busy=1, cmd_oe=1, cmd_out=0 (start bit).
  - Bit k is driven during cycles N+1+k·DIV .. N+(k+1)·DIV.
- Edge N+48·DIV+1: busy=0, cmd_oe=0, cmd_out=1, done=1 for exactly one cycle.
  - State is IDLE in the done cycle; a start asserted in that cycle is accepted, giving back-to-back frames with one idle-high cycle between them.
- Total latency from the accept edge to the done rise is 48·DIV+1 cycles.
- DIV=1: one bit per clock with no stalls.
- crc_out is updated at the last HDR bit's advance edge, before the first CRC bit is driven.

## Test plan
- CMD0, arg 0x00000000, DIV=1 -> serial frame 0x40_00000000_95, crc_out=0x4A, done at cycle 49 after accept.
- CMD8, arg 0x000001AA, DIV=2 -> frame 0x48_000001AA_87, crc_out=0x43, each bit held 2 cycles, done at cycle 97.
- CMD17 then CMD55, arg 0, with start held high continuously, DIV=3:
  - frames 0x51_00000000_55 (crc 0x2A) and 0x77_00000000_65 (crc 0x32);
  - exactly one idle cycle with cmd_out=1/cmd_oe=0 between them;
  - two done pulses.
- start pulsed at bit 20 of a frame in flight -> ignored; frame bits unchanged; single done.
- RST driven low at bit 30 for one cycle -> next edge cmd_oe=0, cmd_out=1, busy=0, crc_out=0, no done; a subsequent CMD0 yields a correct 0x95 trailer.
- cmd_index/cmd_arg toggled every cycle after accept -> frame matches the values latched at accept.
